dmem_wb_stage: RTL and testbench

- Parametrised successor to the single-cycle data memory plus MEM/WB register plus write-back mux.
- Merges all three into one stage that sits between the EX/MEM register and the register file write port.
- Adds:
  - a valid/ready handshake
  - configurable memory wait states
  - byte/half/word accesses with sign or zero extension
  - misalignment detection
  - pipeline flush

---
 rtl/dmem_wb_stage.sv | 240 ++++++++++++++++++++++++
 tb/tb_dmem_wb_stage.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_wb_stage.sv
// dmem_wb_stage: data memory, MEM/WB register and write-back mux merged
// into one handshaked stage between EX/MEM and the register file port.
//
// One operation is in flight at a time. It is captured in IDLE, waits
// WAIT_CYCLES cycles in BUSY, and completes at the single DONE edge. At that
// edge the store commits and the w_* outputs are registered. Flush drops the
// in-flight operation. Flush asserted in IDLE blocks acceptance.
//
// Optional build feature, macro DMEM_PARITY_EN: keeps one even-parity bit per
// stored byte, checks it on loads, and reports a mismatch on w_perr. A
// mismatch also suppresses the register write.

module dmem_wb_stage #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 0,
  parameter int DEST_W      = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic              m_wreg,
  input  logic              m_m2reg,
  input  logic              m_wmem,
  input  logic [1:0]        m_size,
  input  logic              m_unsigned,
  input  logic [DEST_W-1:0] m_dest,
  input  logic [31:0]       m_r,
  input  logic [31:0]       m_qb,
  input  logic              flush,
  output logic              w_valid,
  output logic              w_wreg,
  output logic [DEST_W-1:0] w_dest,
  output logic [31:0]       w_data,
  output logic              w_misalign
`ifdef DMEM_PARITY_EN
  ,
  output logic              w_perr
`endif
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [2:0]        wcnt;

  // Operation fields captured at accept and held until the next accept
  logic              c_wreg;
  logic              c_m2reg;
  logic              c_wmem;
  logic [1:0]        c_size;
  logic              c_unsigned;
  logic [DEST_W-1:0] c_dest;
  logic [31:0]       c_r;
  logic [31:0]       c_qb;

  logic [31:0]       mem [DEPTH];

  logic              accept;
  logic              done_fire;
  logic [AW-1:0]     widx;
  logic              misalign;
  logic              is_load;
  logic              do_store;
  logic              perr;
  logic [31:0]       rword;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [3:0]        lane_be;
  logic [31:0]       st_data;
  logic [31:0]       load_val;
  logic [31:0]       wb_data;

  assign m_ready   = (state == S_IDLE) && !flush;
  assign accept    = m_valid && m_ready;
  assign done_fire = (state == S_DONE) && !flush;

  // Upper address bits are dropped here, so addresses wrap at 4*DEPTH bytes
  assign widx     = c_r[AW+1:2];
  assign misalign = ((c_size == 2'b01) && c_r[0]) ||
                    (c_size[1] && (c_r[1:0] != 2'b00));
  assign is_load  = c_m2reg && !c_wmem;
  assign do_store = done_fire && c_wmem && !misalign;

  assign rword    = mem[widx];
  assign byte_sel = rword[{c_r[1:0], 3'b000} +: 8];
  assign half_sel = c_r[1] ? rword[31:16] : rword[15:0];

  // Lane enables, replicated store data and extended load value for the access size
  always_comb begin
    lane_be  = 4'b1111;
    st_data  = c_qb;
    load_val = rword;
    case (c_size)
      2'b00: begin
        lane_be  = 4'b0001 << c_r[1:0];
        st_data  = {4{c_qb[7:0]}};
        load_val = c_unsigned ? {24'h000000, byte_sel}
                              : {{24{byte_sel[7]}}, byte_sel};
      end
      2'b01: begin
        lane_be  = c_r[1] ? 4'b1100 : 4'b0011;
        st_data  = {2{c_qb[15:0]}};
        load_val = c_unsigned ? {16'h0000, half_sel}
                              : {{16{half_sel[15]}}, half_sel};
      end
      default: begin
        lane_be  = 4'b1111;
        st_data  = c_qb;
        load_val = rword;
      end
    endcase
  end

`ifdef DMEM_PARITY_EN
  logic [3:0] mpar [DEPTH];
  logic [3:0] perr_lane;

  // Recompute parity of the accessed lanes and compare with the stored bits
  always_comb begin
    perr_lane = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      perr_lane[i] = lane_be[i] && ((^rword[8*i +: 8]) != mpar[widx][i]);
    end
  end

  assign perr = is_load && !misalign && (|perr_lane);

  // Parity bits follow every byte written by a store
  always_ff @(posedge clk) begin
    if (do_store) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_be[i]) begin
          mpar[widx][i] <= ^st_data[8*i +: 8];
        end
      end
    end
  end
`else
  assign perr = 1'b0;
`endif

  // Misaligned operations report the address; loads return memory, others the ALU result
  assign wb_data = (!misalign && is_load) ? load_val : c_r;

  // Byte-lane store commit at the DONE edge; memory itself is never reset
  always_ff @(posedge clk) begin
    if (do_store) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_be[i]) begin
          mem[widx][8*i +: 8] <= st_data[8*i +: 8];
        end
      end
    end
  end

  // Control FSM, operation capture and registered write-back outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wcnt       <= 3'd0;
      c_wreg     <= 1'b0;
      c_m2reg    <= 1'b0;
      c_wmem     <= 1'b0;
      c_size     <= 2'b00;
      c_unsigned <= 1'b0;
      c_dest     <= '0;
      c_r        <= 32'h0;
      c_qb       <= 32'h0;
      w_valid    <= 1'b0;
      w_wreg     <= 1'b0;
      w_misalign <= 1'b0;
      w_dest     <= '0;
      w_data     <= 32'h0;
`ifdef DMEM_PARITY_EN
      w_perr     <= 1'b0;
`endif
    end else begin
      w_valid    <= 1'b0;
      w_wreg     <= 1'b0;
      w_misalign <= 1'b0;
`ifdef DMEM_PARITY_EN
      w_perr     <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (accept) begin
            c_wreg     <= m_wreg;
            c_m2reg    <= m_m2reg;
            c_wmem     <= m_wmem;
            c_size     <= m_size;
            c_unsigned <= m_unsigned;
            c_dest     <= m_dest;
            c_r        <= m_r;
            c_qb       <= m_qb;
            wcnt       <= 3'(WAIT_CYCLES);
            if (WAIT_CYCLES == 0) begin
              state <= S_DONE;
            end else begin
              state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (flush) begin
            state <= S_IDLE;
            wcnt  <= 3'd0;
          end else if (wcnt == 3'd1) begin
            state <= S_DONE;
            wcnt  <= 3'd0;
          end else begin
            wcnt <= wcnt - 3'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          if (!flush) begin
            w_valid    <= 1'b1;
            w_wreg     <= c_wreg && !misalign && !perr;
            w_dest     <= c_dest;
            w_data     <= wb_data;
            w_misalign <= misalign;
`ifdef DMEM_PARITY_EN
            w_perr     <= perr;
`endif
          end
        end
        default: begin
          state <= S_IDLE;
          wcnt  <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_wb_stage.sv
// tb_dmem_wb_stage: two dmem_wb_stage instances (WAIT_CYCLES 0 and 3)
// are checked against a byte-array memory model. The model computes expected
// write-back data, enables, misalignment and latency from the access rules.

module tb_dmem_wb_stage;

  localparam int DEPTH = 64;
  localparam int NBYTE = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        m_wreg, m_m2reg, m_wmem, m_unsigned;
  logic [1:0]  m_size;
  logic [4:0]  m_dest;
  logic [31:0] m_r, m_qb;
  logic        m_valid0, m_valid3, flush0, flush3;

  logic        m_ready0, w_valid0, w_wreg0, w_misalign0;
  logic [4:0]  w_dest0;
  logic [31:0] w_data0;
  logic        m_ready3, w_valid3, w_wreg3, w_misalign3;
  logic [4:0]  w_dest3;
  logic [31:0] w_data3;
`ifdef DMEM_PARITY_EN
  logic        w_perr0, w_perr3;
`endif

  int passCount  = 0;
  int checkCount = 0;

  logic [7:0] refmem  [2][NBYTE];
  logic       corrupt [2][NBYTE];

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  dmem_wb_stage #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .DEST_W(5)) dut0 (
    .clk(clk), .rst_n(rst_n), .m_valid(m_valid0), .m_ready(m_ready0),
    .m_wreg(m_wreg), .m_m2reg(m_m2reg), .m_wmem(m_wmem), .m_size(m_size),
    .m_unsigned(m_unsigned), .m_dest(m_dest), .m_r(m_r), .m_qb(m_qb),
    .flush(flush0), .w_valid(w_valid0), .w_wreg(w_wreg0), .w_dest(w_dest0),
    .w_data(w_data0), .w_misalign(w_misalign0)
`ifdef DMEM_PARITY_EN
    , .w_perr(w_perr0)
`endif
  );

  dmem_wb_stage #(.DEPTH(DEPTH), .WAIT_CYCLES(3), .DEST_W(5)) dut3 (
    .clk(clk), .rst_n(rst_n), .m_valid(m_valid3), .m_ready(m_ready3),
    .m_wreg(m_wreg), .m_m2reg(m_m2reg), .m_wmem(m_wmem), .m_size(m_size),
    .m_unsigned(m_unsigned), .m_dest(m_dest), .m_r(m_r), .m_qb(m_qb),
    .flush(flush3), .w_valid(w_valid3), .w_wreg(w_wreg3), .w_dest(w_dest3),
    .w_data(w_data3), .w_misalign(w_misalign3)
`ifdef DMEM_PARITY_EN
    , .w_perr(w_perr3)
`endif
  );

  // Reference model: byte-addressed little-endian memory, updates on stores
  task automatic model_op(input int which, input logic [1:0] size, input logic uns,
                          input logic wreg, input logic m2reg, input logic wmem,
                          input logic [31:0] r, input logic [31:0] qb,
                          output logic [31:0] edata, output logic ewreg,
                          output logic emis, output logic eperr);
    int a, n;
    logic [31:0] v;
    logic isLoad;
    a = int'(r % NBYTE);
    n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    emis = (a % n) != 0;
    isLoad = m2reg && !wmem;
    v = 32'h0;
    eperr = 1'b0;
    if (!emis) begin
      for (int i = 0; i < n; i++) begin
        v = v | (32'(refmem[which][a + i]) << (8 * i));
        if (corrupt[which][a + i]) eperr = 1'b1;
      end
      if (!uns && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    end
    eperr = eperr && isLoad && !emis;
    edata = (!emis && isLoad) ? v : r;
    ewreg = wreg && !emis && !eperr;
    if (!emis && wmem) begin
      for (int i = 0; i < n; i++) begin
        refmem[which][a + i] = 8'(qb >> (8 * i));
        corrupt[which][a + i] = 1'b0;
      end
    end
  endtask

  // One complete operation on dut0 (which=0) or dut3 (which=1), checked against the model
  task automatic issue(input int which, input logic [1:0] size, input logic uns,
                       input logic wreg, input logic m2reg, input logic wmem,
                       input logic [4:0] dest, input logic [31:0] r, input logic [31:0] qb,
                       output logic [31:0] odata, output logic owreg, output logic omis);
    logic [31:0] edata;
    logic ewreg, emis, eperr, got;
    int lat, wantLat, dn;
    wantLat = (which == 0) ? 1 : 4;
    dn = (which == 0) ? 0 : 3;
    @(negedge clk);
    m_size = size; m_unsigned = uns; m_wreg = wreg; m_m2reg = m2reg;
    m_wmem = wmem; m_dest = dest; m_r = r; m_qb = qb;
    if (which == 0) m_valid0 = 1'b1; else m_valid3 = 1'b1;
    #1;
    checkCount++;
    if (((which == 0) ? m_ready0 : m_ready3) !== 1'b1)
      $display("[TB] FAIL ready: dut%0d m_ready=%b want 1", dn, (which == 0) ? m_ready0 : m_ready3);
    else passCount++;
    @(posedge clk);
    #1;
    m_valid0 = 1'b0;
    m_valid3 = 1'b0;
    model_op(which, size, uns, wreg, m2reg, wmem, r, qb, edata, ewreg, emis, eperr);
    got = 1'b0;
    lat = 0;
    while (got !== 1'b1 && lat < 16) begin
      @(posedge clk);
      #1;
      lat++;
      got = (which == 0) ? w_valid0 : w_valid3;
    end
    odata = (which == 0) ? w_data0 : w_data3;
    owreg = (which == 0) ? w_wreg0 : w_wreg3;
    omis  = (which == 0) ? w_misalign0 : w_misalign3;
    checkCount++;
    if (got !== 1'b1 || lat != wantLat)
      $display("[TB] FAIL latency: dut%0d got=%b cycles=%0d want %0d", dn, got, lat, wantLat);
    else passCount++;
    checkCount++;
    if (odata !== edata)
      $display("[TB] FAIL w_data: dut%0d addr=%h size=%0d got %h want %h", dn, r, size, odata, edata);
    else passCount++;
    checkCount++;
    if (owreg !== ewreg)
      $display("[TB] FAIL w_wreg: dut%0d addr=%h got %b want %b", dn, r, owreg, ewreg);
    else passCount++;
    checkCount++;
    if (omis !== emis)
      $display("[TB] FAIL w_misalign: dut%0d addr=%h size=%0d got %b want %b", dn, r, size, omis, emis);
    else passCount++;
    checkCount++;
    if (((which == 0) ? w_dest0 : w_dest3) !== dest)
      $display("[TB] FAIL w_dest: dut%0d got %0d want %0d", dn, (which == 0) ? w_dest0 : w_dest3, dest);
    else passCount++;
`ifdef DMEM_PARITY_EN
    checkCount++;
    if (((which == 0) ? w_perr0 : w_perr3) !== eperr)
      $display("[TB] FAIL w_perr: dut%0d got %b want %b", dn, (which == 0) ? w_perr0 : w_perr3, eperr);
    else passCount++;
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_valid0 = 1'b0; m_valid3 = 1'b0; flush0 = 1'b0; flush3 = 1'b0;
    m_wreg = 1'b0; m_m2reg = 1'b0; m_wmem = 1'b0; m_size = 2'b00;
    m_unsigned = 1'b0; m_dest = 5'd0; m_r = 32'h0; m_qb = 32'h0;
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < NBYTE; i++) corrupt[w][i] = 1'b0;
    repeat (2) @(negedge clk);
    checkCount++;
    if ({w_valid0, w_wreg0, w_misalign0, w_valid3, w_wreg3, w_misalign3} !== 6'b0)
      $display("[TB] FAIL reset_pulses: got %b want 000000",
               {w_valid0, w_wreg0, w_misalign0, w_valid3, w_wreg3, w_misalign3});
    else passCount++;
    checkCount++;
    if (w_data0 !== 32'h0 || w_dest0 !== 5'd0 || w_data3 !== 32'h0 || w_dest3 !== 5'd0)
      $display("[TB] FAIL reset_data: got %h/%0d %h/%0d want 0", w_data0, w_dest0, w_data3, w_dest3);
    else passCount++;
    rst_n = 1'b1;
    #1;
    checkCount++;
    if (m_ready0 !== 1'b1 || m_ready3 !== 1'b1)
      $display("[TB] FAIL reset_ready: got %b%b want 11", m_ready0, m_ready3);
    else passCount++;
  endtask

  // Give every word a known value so later loads have defined expectations
  task automatic test_fill();
    logic [31:0] d;
    logic wr, ms;
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < DEPTH; i++)
        issue(w, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'(4 * i), $urandom, d, wr, ms);
  endtask

  task automatic test_word_store_load();
    logic [31:0] d;
    logic wr, ms;
    issue(0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h10, 32'hA00000AA, d, wr, ms);
    issue(0, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 32'h10, 32'h0, d, wr, ms);
    checkCount++;
    if (d !== 32'hA00000AA || wr !== 1'b1 || w_dest0 !== 5'd5)
      $display("[TB] FAIL word_load: got %h wreg=%b dest=%0d want a00000aa 1 5", d, wr, w_dest0);
    else passCount++;
  endtask

  task automatic test_byte_ext();
    logic [31:0] d;
    logic wr, ms;
    issue(0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h10, 32'h11223344, d, wr, ms);
    issue(0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h13, 32'h12345680, d, wr, ms);
    issue(0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 5'd1, 32'h13, 32'h0, d, wr, ms);
    checkCount++;
    if (d !== 32'hFFFFFF80) $display("[TB] FAIL lb_signed: got %h want ffffff80", d);
    else passCount++;
    issue(0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 5'd2, 32'h13, 32'h0, d, wr, ms);
    checkCount++;
    if (d !== 32'h00000080) $display("[TB] FAIL lb_unsigned: got %h want 00000080", d);
    else passCount++;
    issue(0, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 5'd3, 32'h10, 32'h0, d, wr, ms);
    checkCount++;
    if (d !== 32'h80223344) $display("[TB] FAIL lw_after_sb: got %h want 80223344", d);
    else passCount++;
    issue(0, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 5'd4, 32'h12, 32'h0, d, wr, ms);
    checkCount++;
    if (d !== 32'hFFFF8022) $display("[TB] FAIL lh_signed: got %h want ffff8022", d);
    else passCount++;
  endtask

  task automatic test_misalign();
    logic [31:0] d;
    logic wr, ms;
    issue(0, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 5'd6, 32'h06, 32'h0, d, wr, ms);
    checkCount++;
    if (ms !== 1'b1 || wr !== 1'b0 || d !== 32'h00000006)
      $display("[TB] FAIL lw_misalign: got mis=%b wreg=%b data=%h want 1 0 00000006", ms, wr, d);
    else passCount++;
    issue(0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h04, 32'h55667788, d, wr, ms);
    issue(0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h05, 32'h0000BEEF, d, wr, ms);
    issue(0, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 5'd7, 32'h04, 32'h0, d, wr, ms);
    checkCount++;
    if (d !== 32'h55667788) $display("[TB] FAIL sh_misalign_nowrite: got %h want 55667788", d);
    else passCount++;
  endtask

  task automatic test_flush();
    logic [31:0] d;
    logic wr, ms, sawValid;
    issue(1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h20, 32'h01020304, d, wr, ms);
    @(negedge clk);
    m_size = 2'b10; m_wmem = 1'b1; m_m2reg = 1'b0; m_wreg = 1'b0;
    m_r = 32'h20; m_qb = 32'hDEADBEEF; m_valid3 = 1'b1;
    @(posedge clk);
    #1;
    m_valid3 = 1'b0;
    @(posedge clk);
    #1;
    flush3 = 1'b1;
    @(posedge clk);
    #1;
    flush3 = 1'b0;
    #1;
    checkCount++;
    if (m_ready3 !== 1'b1) $display("[TB] FAIL flush_ready: got %b want 1", m_ready3);
    else passCount++;
    sawValid = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (w_valid3 !== 1'b0) sawValid = 1'b1;
    end
    checkCount++;
    if (sawValid !== 1'b0) $display("[TB] FAIL flush_busy_valid: got %b want 0", sawValid);
    else passCount++;
    @(negedge clk);
    m_qb = 32'hCAFEF00D; flush3 = 1'b1; m_valid3 = 1'b1;
    #1;
    checkCount++;
    if (m_ready3 !== 1'b0) $display("[TB] FAIL flush_idle_ready: got %b want 0", m_ready3);
    else passCount++;
    @(posedge clk);
    #1;
    m_valid3 = 1'b0;
    flush3 = 1'b0;
    sawValid = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (w_valid3 !== 1'b0) sawValid = 1'b1;
    end
    checkCount++;
    if (sawValid !== 1'b0) $display("[TB] FAIL flush_idle_valid: got %b want 0", sawValid);
    else passCount++;
    issue(1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 5'd9, 32'h20, 32'h0, d, wr, ms);
    checkCount++;
    if (d !== 32'h01020304) $display("[TB] FAIL flush_mem_unchanged: got %h want 01020304", d);
    else passCount++;
  endtask

  task automatic test_reset_mid_busy();
    logic [31:0] d;
    logic wr, ms;
    issue(1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 5'd7, 32'h20, 32'h0, d, wr, ms);
    @(negedge clk);
    m_size = 2'b10; m_wmem = 1'b1; m_m2reg = 1'b0; m_wreg = 1'b1; m_dest = 5'd3;
    m_r = 32'h20; m_qb = 32'h11111111; m_valid3 = 1'b1;
    @(posedge clk);
    #1;
    m_valid3 = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkCount++;
    if ({w_valid3, w_wreg3, w_misalign3} !== 3'b0 || w_dest3 !== 5'd0 || w_data3 !== 32'h0 ||
        w_data0 !== 32'h0)
      $display("[TB] FAIL reset_async: got v=%b dest=%0d data=%h data0=%h want all 0",
               w_valid3, w_dest3, w_data3, w_data0);
    else passCount++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkCount++;
    if (m_ready3 !== 1'b1) $display("[TB] FAIL reset_release_ready: got %b want 1", m_ready3);
    else passCount++;
    issue(1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 5'd8, 32'h20, 32'h0, d, wr, ms);
    checkCount++;
    if (d !== 32'h01020304) $display("[TB] FAIL reset_no_store: got %h want 01020304", d);
    else passCount++;
    issue(0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h100, 32'h13572468, d, wr, ms);
    issue(0, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 5'd10, 32'h000, 32'h0, d, wr, ms);
    checkCount++;
    if (d !== 32'h13572468) $display("[TB] FAIL addr_alias: got %h want 13572468", d);
    else passCount++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic wr, ms;
    issue(0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h40, 32'h0BADF00D, d, wr, ms);
    issue(0, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 5'd11, 32'h40, 32'h0, d, wr, ms);
    checkCount++;
    if (d !== 32'h0BADF00D) $display("[TB] FAIL store_load_hazard: got %h want 0badf00d", d);
    else passCount++;
    @(posedge clk);
    #1;
    checkCount++;
    if (w_valid0 !== 1'b0 || w_wreg0 !== 1'b0 || w_data0 !== 32'h0BADF00D || w_dest0 !== 5'd11)
      $display("[TB] FAIL pulse_hold: got v=%b wreg=%b data=%h dest=%0d want 0 0 0badf00d 11",
               w_valid0, w_wreg0, w_data0, w_dest0);
    else passCount++;
  endtask

  task automatic test_random(input int which, input int count);
    logic [31:0] d, addr;
    logic wr, ms, wmem, m2reg;
    logic [1:0] size;
    for (int k = 0; k < count; k++) begin
      size = 2'($urandom_range(0, 3));
      addr = $urandom_range(0, 1023);
      if ($urandom_range(0, 3) != 0)
        addr = addr & ~((size == 2'b00) ? 32'd0 : (size == 2'b01) ? 32'd1 : 32'd3);
      wmem = 1'($urandom_range(0, 1));
      m2reg = wmem ? ($urandom_range(0, 7) == 0) : 1'($urandom_range(0, 1));
      issue(which, size, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), m2reg, wmem,
            5'($urandom_range(0, 31)), addr, $urandom, d, wr, ms);
    end
  endtask

`ifdef DMEM_PARITY_EN
  task automatic test_parity();
    logic [31:0] d;
    logic wr, ms;
    issue(0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h30, 32'h0F0F0F0F, d, wr, ms);
    dut0.mem[12][9] = ~dut0.mem[12][9];
    refmem[0][8'h31] = refmem[0][8'h31] ^ 8'h02;
    corrupt[0][8'h31] = 1'b1;
    issue(0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 5'd12, 32'h30, 32'h0, d, wr, ms);
    checkCount++;
    if (w_perr0 !== 1'b0 || wr !== 1'b1) $display("[TB] FAIL perr_clean: got %b/%b want 0/1", w_perr0, wr);
    else passCount++;
    issue(0, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 5'd13, 32'h30, 32'h0, d, wr, ms);
    checkCount++;
    if (w_perr0 !== 1'b1 || wr !== 1'b0) $display("[TB] FAIL perr_flip: got %b/%b want 1/0", w_perr0, wr);
    else passCount++;
  endtask
`endif

  // Safety net so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Scenario sequence
  initial begin
    test_reset();
    test_fill();
    test_word_store_load();
    test_byte_ext();
    test_misalign();
    test_back_to_back();
    test_flush();
    test_reset_mid_busy();
`ifdef DMEM_PARITY_EN
    test_parity();
`endif
    test_random(0, 200);
    test_random(1, 40);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
